// File: rtl/riscv_dcache.sv
`default_nettype none
// ============================================================================
// Module   : riscv_dcache
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache for a
//            RISC-V core. Line refills fetch one word per memory transaction.
//            The cache never holds dirty data.
// Ports    : clk / reset (async, active-low)
//            cpu_*     : CPU load/store port; the CPU holds its inputs while
//                        stall is high
//            mem_req_* : valid/ready request channel to backing memory
//            mem_resp_*: in-order read-data return from backing memory
// Revision : 1.0 - initial release
// ============================================================================
module riscv_dcache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_re,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rw,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_mask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);
    localparam int WB      = $clog2(WORDS);
    localparam int LB      = $clog2(LINES);
    // A one-word line still needs a 1-bit index signal; it is forced to zero.
    localparam int WI_W    = (WORDS > 1) ? WB : 1;
    localparam int TAG_LSB = 2 + WB + LB;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam logic [31:0]     LINE_MASK = ~((32'(WORDS) << 2) - 32'd1);
    localparam logic [WI_W-1:0] LAST_BEAT = WI_W'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REFILL_REQ  = 3'd1,
        REFILL_WAIT = 3'd2,
        WR_REQ      = 3'd3,
        DONE        = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WI_W-1:0]  beat_q, beat_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic             stall_q, stall_d;
    logic [31:0]      cpu_dout_q, cpu_dout_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic             mem_req_valid_q, mem_req_valid_d;
    logic             mem_req_rw_q, mem_req_rw_d;
    logic [31:0]      mem_req_addr_q, mem_req_addr_d;
    logic [31:0]      mem_req_data_q, mem_req_data_d;
    logic [3:0]       mem_req_mask_q, mem_req_mask_d;

    // Tag/data storage carries no reset; only the valid bits qualify it.
    logic [31:0]      data_q [LINES][WORDS];
    logic [TAG_W-1:0] tag_q  [LINES];

    logic             arr_we;
    logic [LB-1:0]    arr_line;
    logic [WI_W-1:0]  arr_word;
    logic [31:0]      arr_wdata;
    logic             tag_we;

    // Address fields of the live CPU request and of the latched miss.
    logic [LB-1:0]    cpu_line, miss_line;
    logic [WI_W-1:0]  cpu_word, miss_word;
    logic [TAG_W-1:0] cpu_tag, miss_tag;
    logic             cpu_hit;
    logic [31:0]      cpu_rd_word;
    logic [31:0]      store_word;

    assign cpu_line    = LB'(cpu_addr >> (2 + WB));
    assign cpu_word    = (WORDS > 1) ? WI_W'(cpu_addr >> 2) : '0;
    assign cpu_tag     = TAG_W'(cpu_addr >> TAG_LSB);
    assign miss_line   = LB'(req_addr_q >> (2 + WB));
    assign miss_word   = (WORDS > 1) ? WI_W'(req_addr_q >> 2) : '0;
    assign miss_tag    = TAG_W'(req_addr_q >> TAG_LSB);
    assign cpu_hit     = valid_q[cpu_line] && (tag_q[cpu_line] == cpu_tag);
    assign cpu_rd_word = data_q[cpu_line][cpu_word];

    // Byte-lane merge of store data into the currently cached word.
    always_comb begin
        store_word = cpu_rd_word;
        for (int b = 0; b < 4; b++) begin
            if (cpu_we[b]) begin
                store_word[8*b +: 8] = cpu_din[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        valid_d         = valid_q;
        stall_d         = stall_q;
        cpu_dout_d      = cpu_dout_q;
        req_addr_d      = req_addr_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_rw_d    = mem_req_rw_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_data_d  = mem_req_data_q;
        mem_req_mask_d  = mem_req_mask_q;
        arr_we          = 1'b0;
        arr_line        = miss_line;
        arr_word        = beat_q;
        arr_wdata       = mem_resp_data;
        tag_we          = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_we != 4'b0000) begin
                    // Write-through: update the line only on a hit, always
                    // forward the store to memory.
                    if (cpu_hit) begin
                        arr_we    = 1'b1;
                        arr_line  = cpu_line;
                        arr_word  = cpu_word;
                        arr_wdata = store_word;
                    end
                    mem_req_valid_d = 1'b1;
                    mem_req_rw_d    = 1'b1;
                    mem_req_addr_d  = {cpu_addr[31:2], 2'b00};
                    mem_req_data_d  = cpu_din;
                    mem_req_mask_d  = cpu_we;
                    stall_d         = 1'b1;
                    state_d         = WR_REQ;
                end else if (cpu_re) begin
                    if (cpu_hit) begin
                        cpu_dout_d = cpu_rd_word;
                    end else begin
                        req_addr_d      = cpu_addr;
                        beat_d          = '0;
                        stall_d         = 1'b1;
                        mem_req_valid_d = 1'b1;
                        mem_req_rw_d    = 1'b0;
                        mem_req_addr_d  = cpu_addr & LINE_MASK;
                        mem_req_data_d  = 32'h0;
                        mem_req_mask_d  = 4'h0;
                        state_d         = REFILL_REQ;
                    end
                end
            end
            REFILL_REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    arr_we = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        valid_d[miss_line] = 1'b1;
                        tag_we             = 1'b1;
                        // The requested word may be the one arriving now,
                        // which is not yet visible in the data array.
                        cpu_dout_d = (miss_word == beat_q) ? mem_resp_data
                                                           : data_q[miss_line][miss_word];
                        stall_d    = 1'b0;
                        state_d    = DONE;
                    end else begin
                        beat_d          = beat_q + 1'b1;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = (req_addr_q & LINE_MASK)
                                        | (32'(beat_q + 1'b1) << 2);
                        state_d         = REFILL_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    stall_d         = 1'b0;
                    state_d         = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            beat_q          <= '0;
            valid_q         <= '0;
            stall_q         <= 1'b0;
            cpu_dout_q      <= 32'h0;
            req_addr_q      <= 32'h0;
            mem_req_valid_q <= 1'b0;
            mem_req_rw_q    <= 1'b0;
            mem_req_addr_q  <= 32'h0;
            mem_req_data_q  <= 32'h0;
            mem_req_mask_q  <= 4'h0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            valid_q         <= valid_d;
            stall_q         <= stall_d;
            cpu_dout_q      <= cpu_dout_d;
            req_addr_q      <= req_addr_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_rw_q    <= mem_req_rw_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_data_q  <= mem_req_data_d;
            mem_req_mask_q  <= mem_req_mask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_q[arr_line][arr_word] <= arr_wdata;
        end
        if (tag_we) begin
            tag_q[miss_line] <= miss_tag;
        end
    end

    assign cpu_dout      = cpu_dout_q;
    assign stall         = stall_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_rw    = mem_req_rw_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_data  = mem_req_data_q;
    assign mem_req_mask  = mem_req_mask_q;

endmodule
`default_nettype wire
